// File: rtl/mips_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS core, with bounded memory waits.
// Optional perf counters are enabled by defining MIPS_MC_CTRL_PERF_EN.
module mips_mc_ctrl #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        alu_zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_op,
  output logic [1:0]  alu_src_b,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic [1:0]  rf_wdsel,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        illegal,
  output logic        bus_err,
  output logic [3:0]  state_o,
  output logic [31:0] cyc_cnt,
  output logic [31:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXA    = 4'd3,
    S_EXM    = 4'd4,
    S_EXB    = 4'd5,
    S_MEM    = 4'd6,
    S_WBA    = 4'd7,
    S_WBM    = 4'd8
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TO_CNT = TIMEOUT_W'(TIMEOUT);

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic                 timeout;
  logic                 is_r, is_addu, is_subu, is_jr, is_nop;
  logic                 is_ori, is_lw, is_sw, is_beq, is_lui, is_jal;

  assign is_r    = (op == 6'h00);
  assign is_addu = is_r && (funct == 6'h21);
  assign is_subu = is_r && (funct == 6'h23);
  assign is_jr   = is_r && (funct == 6'h08);
  assign is_nop  = is_r && (funct == 6'h00);
  assign is_ori  = (op == 6'h0D);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_lui  = (op == 6'h0F);
  assign is_jal  = (op == 6'h03);

  assign timeout = (TIMEOUT != 0) && (wait_q == TO_CNT);
  assign state_o = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Wait counter only counts stalled FETCH/MEM cycles; every other path clears it.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    alu_op    = 3'd0;
    alu_src_b = 2'd0;
    rf_we     = 1'b0;
    rf_wsel   = 2'd0;
    rf_wdsel  = 2'd0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          bus_err = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        if (is_jal) begin
          pc_we    = 1'b1;
          pc_src   = 2'd2;
          rf_we    = 1'b1;
          rf_wsel  = 2'd2;
          rf_wdsel = 2'd2;
        end else if (is_jr) begin
          pc_we  = 1'b1;
          pc_src = 2'd3;
        end else if (is_beq) begin
          state_d = S_EXB;
        end else if (is_addu || is_subu || is_ori || is_lui) begin
          state_d = S_EXA;
        end else if (is_lw || is_sw) begin
          state_d = S_EXM;
        end else if (!is_nop) begin
          illegal = 1'b1;
        end
      end
      S_EXA: begin
        if (is_subu) begin
          alu_op = 3'd1;
        end else if (is_ori) begin
          alu_op    = 3'd2;
          alu_src_b = 2'd1;
        end else if (is_lui) begin
          alu_op    = 3'd3;
          alu_src_b = 2'd1;
        end
        state_d = S_WBA;
      end
      S_EXM: begin
        alu_src_b = 2'd2;
        state_d   = S_MEM;
      end
      S_EXB: begin
        alu_op  = 3'd1;
        pc_we   = alu_zero;
        pc_src  = 2'd1;
        state_d = S_FETCH;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (dmem_ready) begin
          state_d = is_sw ? S_FETCH : S_WBM;
        end else if (timeout) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WBA: begin
        rf_we   = 1'b1;
        rf_wsel = is_r ? 2'd1 : 2'd0;
        state_d = S_FETCH;
      end
      S_WBM: begin
        rf_we    = 1'b1;
        rf_wdsel = 2'd1;
        state_d  = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef MIPS_MC_CTRL_PERF_EN
  logic        retire;
  logic [31:0] cyc_q, instr_q;

  assign retire = (state_d == S_FETCH) && (state_q != S_IDLE) && (state_q != S_FETCH)
                  && !illegal && !bus_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q   <= '0;
      instr_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (retire) instr_q <= instr_q + 32'd1;
    end
  end

  assign cyc_cnt   = cyc_q;
  assign instr_cnt = instr_q;
`else
  assign cyc_cnt   = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: stimulus queues the expected control word per cycle,
// a negedge monitor pops and compares it against the DUT outputs and cycle count.
module tb_mips_mc_ctrl;

`ifdef MIPS_MC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic       imem_req, ir_we, pc_we;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic [1:0] alu_src_b;
    logic       rf_we;
    logic [1:0] rf_wsel, rf_wdsel;
    logic       dmem_req, dmem_we, illegal, bus_err;
  } ctl_t;

  typedef struct {
    int    cyc;
    ctl_t  c;
    string nm;
  } exp_t;

  logic        clk = 1'b0, reset = 1'b0;
  logic [5:0]  op = '0, funct = '0;
  logic        alu_zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic        imem_req, ir_we, pc_we, rf_we, dmem_req, dmem_we, illegal, bus_err;
  logic [1:0]  pc_src, alu_src_b, rf_wsel, rf_wdsel;
  logic [2:0]  alu_op;
  logic [3:0]  state_o;
  logic [31:0] cyc_cnt, instr_cnt;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   tcyc = 0;
  int   ec = 0;

  mips_mc_ctrl #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_wdsel(rf_wdsel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .illegal(illegal), .bus_err(bus_err),
    .state_o(state_o), .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) tcyc <= 0;
    else        tcyc <= tcyc + 1;

  // Monitor: one expected control word per clock while stimulus is active.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      ctl_t a;
      e = sb.pop_front();
      a.st = state_o;        a.imem_req = imem_req;   a.ir_we = ir_we;
      a.pc_we = pc_we;       a.pc_src = pc_src;       a.alu_op = alu_op;
      a.alu_src_b = alu_src_b; a.rf_we = rf_we;       a.rf_wsel = rf_wsel;
      a.rf_wdsel = rf_wdsel; a.dmem_req = dmem_req;   a.dmem_we = dmem_we;
      a.illegal = illegal;   a.bus_err = bus_err;
      n_chk++;
      if (a !== e.c || tcyc != e.cyc) begin
        n_fail++;
        $display("FAIL %s: got cycle %0d ctl %h, want cycle %0d ctl %h",
                 e.nm, tcyc, a, e.cyc, e.c);
      end
    end
  end

  // Field order: st imem_req ir_we pc_we pc_src alu_op alu_src_b rf_we rf_wsel rf_wdsel dmem_req dmem_we illegal bus_err
  function automatic ctl_t k(input logic [3:0] st, input logic ireq, irw, pcw,
                             input logic [1:0] pcs, input logic [2:0] aop,
                             input logic [1:0] asb, input logic rfw,
                             input logic [1:0] ws, wd, input logic dreq, dwe, ill, be);
    k = {st, ireq, irw, pcw, pcs, aop, asb, rfw, ws, wd, dreq, dwe, ill, be};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string nm, input ctl_t c);
    exp_t e;
    if (!reset) ec = 0;
    e.cyc = ec; e.c = c; e.nm = nm;
    sb.push_back(e);
    cyc();
    if (reset) ec++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic fetch(input int stalls, input logic [5:0] o, input logic [5:0] f);
    imem_ready = 1'b0;
    repeat (stalls) step("fetch_stall", k(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
    imem_ready = 1'b1; op = o; funct = f;
    step("fetch", k(1,1,1,1,0,0,0,0,0,0,0,0,0,0));
    imem_ready = 1'b0;
  endtask

  initial begin
    cyc();
    repeat (3) step("reset_idle", k(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    reset = 1'b1;
    step("release_idle", k(0,0,0,0,0,0,0,0,0,0,0,0,0,0));

    fetch(0, 6'h00, 6'h21);
    step("addu_dec", k(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("addu_exa", k(3,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("addu_wba", k(7,0,0,0,0,0,0,1,1,0,0,0,0,0));

    fetch(2, 6'h00, 6'h23);
    step("subu_dec", k(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("subu_exa", k(3,0,0,0,0,1,0,0,0,0,0,0,0,0));
    step("subu_wba", k(7,0,0,0,0,0,0,1,1,0,0,0,0,0));

    fetch(0, 6'h0D, 6'h15);
    step("ori_dec", k(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("ori_exa", k(3,0,0,0,0,2,1,0,0,0,0,0,0,0));
    step("ori_wba", k(7,0,0,0,0,0,0,1,0,0,0,0,0,0));

    fetch(0, 6'h23, 6'h00);
    step("lw_dec", k(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("lw_exm", k(4,0,0,0,0,0,2,0,0,0,0,0,0,0));
    dmem_ready = 1'b0;
    repeat (3) step("lw_mem_stall", k(6,0,0,0,0,0,0,0,0,0,1,0,0,0));
    dmem_ready = 1'b1;
    step("lw_mem_done", k(6,0,0,0,0,0,0,0,0,0,1,0,0,0));
    dmem_ready = 1'b0;
    step("lw_wbm", k(8,0,0,0,0,0,0,1,0,1,0,0,0,0));

    fetch(0, 6'h2B, 6'h00);
    step("sw_dec", k(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("sw_exm", k(4,0,0,0,0,0,2,0,0,0,0,0,0,0));
    dmem_ready = 1'b1;
    step("sw_mem", k(6,0,0,0,0,0,0,0,0,0,1,1,0,0));
    dmem_ready = 1'b0;

    fetch(0, 6'h04, 6'h00);
    step("beq_t_dec", k(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
    alu_zero = 1'b1;
    step("beq_t_exb", k(5,0,0,1,1,1,0,0,0,0,0,0,0,0));
    alu_zero = 1'b0;
    fetch(0, 6'h04, 6'h00);
    step("beq_nt_dec", k(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("beq_nt_exb", k(5,0,0,0,1,1,0,0,0,0,0,0,0,0));

    fetch(0, 6'h03, 6'h00);
    step("jal_dec", k(2,0,0,1,2,0,0,1,2,2,0,0,0,0));
    fetch(0, 6'h00, 6'h08);
    step("jr_dec", k(2,0,0,1,3,0,0,0,0,0,0,0,0,0));
    fetch(0, 6'h00, 6'h00);
    step("nop_dec", k(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
    fetch(0, 6'h3F, 6'h00);
    step("ill_op_dec", k(2,0,0,0,0,0,0,0,0,0,0,0,1,0));
    fetch(0, 6'h00, 6'h2A);
    step("ill_funct_dec", k(2,0,0,0,0,0,0,0,0,0,0,0,1,0));

    imem_ready = 1'b0;
    repeat (4) step("to_fetch_stall", k(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
    step("to_fetch_buserr", k(1,1,0,0,0,0,0,0,0,0,0,0,0,1));
    fetch(4, 6'h00, 6'h00);
    step("race_nop_dec", k(2,0,0,0,0,0,0,0,0,0,0,0,0,0));

    fetch(0, 6'h23, 6'h00);
    step("lw_to_dec", k(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("lw_to_exm", k(4,0,0,0,0,0,2,0,0,0,0,0,0,0));
    dmem_ready = 1'b0;
    repeat (4) step("lw_to_stall", k(6,0,0,0,0,0,0,0,0,0,1,0,0,0));
    step("lw_to_buserr", k(6,0,0,0,0,0,0,0,0,0,1,0,0,1));

    chk("instr_cnt_main", instr_cnt, PERF ? 32'd11 : 32'd0);
    chk("cyc_cnt_main", cyc_cnt, PERF ? 32'(ec) : 32'd0);

    fetch(0, 6'h00, 6'h21);
    step("mid_dec", k(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("mid_exa", k(3,0,0,0,0,0,0,0,0,0,0,0,0,0));
    reset = 1'b0;
    repeat (3) step("mid_reset_idle", k(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    reset = 1'b1;
    step("rerelease_idle", k(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    chk("instr_cnt_reset", instr_cnt, 32'd0);
    chk("cyc_cnt_reset", cyc_cnt, PERF ? 32'd1 : 32'd0);
    fetch(1, 6'h0F, 6'h00);
    step("lui_dec", k(2,0,0,0,0,0,0,0,0,0,0,0,0,0));

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
